// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf_pkg
// Purpose : Shared types and defaults for the register-file / writeback slice.
//           Holds the data-width and register-count defaults, the derived
//           address width, the address/data typedefs and the ALU flag struct.
// Config  : RF_R0_ZERO_EN (consumed by rf_wb_stage / rf_bypass_mux, not here)
// Revision: 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int RF_DW       = 8;
  localparam int RF_NUM_REGS = 8;

  // Address width for a given register count. A single-register file still
  // needs a one-bit address so that the ports keep a legal width.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RF_AW = addr_width(RF_NUM_REGS);

  typedef logic [RF_AW-1:0] reg_addr_t;
  typedef logic [RF_DW-1:0] data_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic pari;
  } flags_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_bypass_mux.sv
`default_nettype none
// ============================================================================
// Module  : rf_bypass_mux
// Purpose : One read port of the register file. Selects the pending
//           writeback data when the writeback stage targets the same address,
//           otherwise the architectural register. Addresses beyond NUM_REGS
//           read as 0 from the array (the bypass compare still applies).
// Ports   : i_rd_addr  - read address
//           i_wb_valid - writeback stage holds an uncommitted write
//           i_wb_addr  - writeback destination
//           i_wb_data  - writeback data
//           i_regs     - architectural register array
//           o_rd_data  - resolved read data (combinational)
// Config  : RF_R0_ZERO_EN - address 0 always reads 0, bypass ignored.
// Revision: 1.0 - initial release
// ============================================================================
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter  int DW       = RF_DW,
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int AW       = addr_width(NUM_REGS)
) (
  input  logic [AW-1:0] i_rd_addr,
  input  logic          i_wb_valid,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic [DW-1:0] i_regs [NUM_REGS],
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] w_arr_data;
  logic          w_hit;

  // Decoded array read: an address matching no register (out of range)
  // falls through to the zero default.
  always_comb begin
    w_arr_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_rd_addr == AW'(i)) begin
        w_arr_data = i_regs[i];
      end
    end
  end

  assign w_hit = i_wb_valid && (i_wb_addr == i_rd_addr);

  always_comb begin
    o_rd_data = w_hit ? i_wb_data : w_arr_data;
`ifdef RF_R0_ZERO_EN
    if (i_rd_addr == '0) begin
      o_rd_data = '0;
    end
`endif
  end

endmodule : rf_bypass_mux
`default_nettype wire

// File: rtl/rf_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : rf_wb_stage
// Purpose : Register file plus one-entry writeback stage around the ALU.
//           An ALU result captured with wr_en is held in the writeback stage
//           for one cycle (visible to readers through the bypass) and is
//           committed to the array on the following edge. Flags are captured
//           independently with flag_en.
// Ports   : clk, reset                 - clock, synchronous active-high reset
//           rd_addr_a/b, data_a/b      - operand read ports (combinational)
//           sc_to_alu                  - registered carry fed back to the ALU
//           wr_en, wr_addr, wr_data    - ALU result capture
//           flag_en, sc_in, zero_in, pari_in - ALU flag capture
//           carry_q, zero_q, pari_q    - flag registers
//           wb_pending                 - writeback stage holds a write
// Config  : RF_R0_ZERO_EN - register 0 hardwired to 0; writes to it never
//           enter the writeback stage.
// Revision: 1.0 - initial release
// ============================================================================
module rf_wb_stage
  import rf_pkg::*;
#(
  parameter  int DW       = RF_DW,
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int AW       = addr_width(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  output logic          sc_to_alu,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          flag_en,
  input  logic          sc_in,
  input  logic          zero_in,
  input  logic          pari_in,
  output logic          carry_q,
  output logic          zero_q,
  output logic          pari_q,
  output logic          wb_pending
);

  logic [DW-1:0] regs_q [NUM_REGS];
  logic [DW-1:0] regs_d [NUM_REGS];
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_addr_q,  wb_addr_d;
  logic [DW-1:0] wb_data_q,  wb_data_d;
  flags_t        flags_q,    flags_d;

  always_comb begin
    // Commit the stage contents; an out-of-range address matches no
    // register, so its commit is silently dropped.
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wb_valid_q && (wb_addr_q == AW'(i))) begin
        regs_d[i] = wb_data_q;
      end
    end

    // The stage reloads on the same edge it commits, so a back-to-back write
    // to one address leaves the older value in the array and the newer one
    // in the stage.
`ifdef RF_R0_ZERO_EN
    wb_valid_d = wr_en && (wr_addr != '0);
`else
    wb_valid_d = wr_en;
`endif
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (wr_en) begin
      wb_addr_d = wr_addr;
      wb_data_d = wr_data;
    end

    flags_d = flags_q;
    if (flag_en) begin
      flags_d.carry = sc_in;
      flags_d.zero  = zero_in;
      flags_d.pari  = pari_in;
    end
  end

  // Reset clears the stage valid bit as well as the array, so a write that
  // is pending when reset arrives is discarded rather than committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q     <= '{default: '0};
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      flags_q    <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      flags_q    <= flags_d;
    end
  end

  // Read ports see the writeback stage but never the wr_* inputs, which
  // keeps the ALU loop free of a combinational path.
  rf_bypass_mux #(
    .DW       (DW),
    .NUM_REGS (NUM_REGS)
  ) u_mux_a (
    .i_rd_addr  (rd_addr_a),
    .i_wb_valid (wb_valid_q),
    .i_wb_addr  (wb_addr_q),
    .i_wb_data  (wb_data_q),
    .i_regs     (regs_q),
    .o_rd_data  (data_a)
  );

  rf_bypass_mux #(
    .DW       (DW),
    .NUM_REGS (NUM_REGS)
  ) u_mux_b (
    .i_rd_addr  (rd_addr_b),
    .i_wb_valid (wb_valid_q),
    .i_wb_addr  (wb_addr_q),
    .i_wb_data  (wb_data_q),
    .i_regs     (regs_q),
    .o_rd_data  (data_b)
  );

  assign carry_q    = flags_q.carry;
  assign zero_q     = flags_q.zero;
  assign pari_q     = flags_q.pari;
  assign sc_to_alu  = flags_q.carry;
  assign wb_pending = wb_valid_q;

endmodule : rf_wb_stage
`default_nettype wire
